bytes_transmitter: RTL and testbench
====================================

BYTES_TRANSMITTER -- requirements
Module: bytes_transmitter

Interface
REQ-001 Parameter CLK_DIV, default 4: sck half-period in clk cycles; legal range >=1.
REQ-002 Parameter INTER_BYTE_GAP, default 2: extra clk cycles sck is held low between bytes, ss still low; legal range >=0.
REQ-003 Port clk, input, 1: single system clock; all logic on rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous, active-high.
REQ-005 Port start, input, 1: frame request; sampled only in IDLE.
REQ-006 Port din, input, 32: word to send; byte order din[31:24] first.
REQ-007 Port miso, input, 1: serial data from peripheral.
REQ-008 Port ss, output, 1: slave select, active-low.
REQ-009 Port sck, output, 1: serial clock, SPI mode 0 (idle low).
REQ-010 Port mosi, output, 1: serial data to peripheral, MSB first.
REQ-011 Port busy, output, 1: high while a frame is in progress.
REQ-012 Port done, output, 1: one-cycle pulse at frame end.
REQ-013 Port dout, output, 32: word captured from miso (see Configuration).

Function
REQ-014 FSM states SHALL be IDLE, SHIFT_LO, SHIFT_HI, GAP, HOLD.
REQ-015 IDLE with start=1 SHALL latch din, clear bit/byte counters, and enter SHIFT_LO next cycle with ss=0, busy=1, mosi=din[31].
REQ-016 SHIFT_LO SHALL last CLK_DIV cycles with sck=0, then go to SHIFT_HI.
REQ-017 SHIFT_HI SHALL last CLK_DIV cycles with sck=1; miso sampled on the sck rising edge.
REQ-018 On leaving SHIFT_HI, mosi SHALL advance to the next bit; sck falls in the same cycle.
REQ-019 After bit 7 of bytes 0-2, FSM SHALL enter GAP for INTER_BYTE_GAP cycles (skipped if 0), then SHIFT_LO.
REQ-020 After bit 7 of byte 3, FSM SHALL enter HOLD for CLK_DIV cycles with sck=0.
REQ-021 HOLD exit SHALL drive ss=1, busy=0, done=1 for one cycle, and return to IDLE.
REQ-022 ss low duration SHALL be exactly 64*CLK_DIV + 3*INTER_BYTE_GAP + CLK_DIV cycles.
REQ-023 The latched word SHALL be unaffected by din changes during a frame.
REQ-024 start while busy=1 SHALL be ignored, not queued.
REQ-025 start held high continuously SHALL begin a new frame in the cycle after done; the minimum ss-high gap is one cycle.
REQ-026 Bit counter SHALL be 3 bits and byte counter 2 bits; both wrap to 0 after value 7 / 3 without affecting outputs.
REQ-027 CLK_DIV=1 SHALL produce sck of period 2 clk cycles with no dropped edges.

Reset
REQ-028 rst=1 SHALL immediately force state=IDLE, ss=1, sck=0, mosi=0, busy=0, done=0, dout=0, and counters=0.
REQ-029 Reset mid-frame SHALL abort the frame with no done pulse; the first frame after rst deasserts is a complete frame.

Configuration
REQ-030 Macro BYTES_TRANSMITTER_MISO_CAPTURE_EN defined: miso is shifted in MSB first on every sck rising edge, and dout updates with the full word in the cycle done pulses.
REQ-031 Macro not defined: miso is ignored, dout is constant 0, and the port list is unchanged.

Structure
REQ-032 Shared package spi_pkg SHALL hold the FSM state enum, SPI_WORD_BYTES=4 and SPI_BYTE_BITS=8.
REQ-033 The sck half-period counter SHALL be one sub-module, spi_sck_gen (enable, CLK_DIV, tick output).

Verification
REQ-034 CLK_DIV=4, GAP=2, start with din=0xDEADBEEF, looped to spi_peripheral + bytes_reciever -> receiver out=0xDEADBEEF, bytes DE,AD,BE,EF in order, ss low 266 cycles, one done pulse.
REQ-035 start pulsed again 50 cycles into a frame -> no effect; exactly one frame, busy continuous.
REQ-036 rst asserted 100 cycles into a frame -> same-cycle ss=1, sck=0, no done; next start with din=0x01234567 is received intact.
REQ-037 start held high, din=0x00000000 then 0xFFFFFFFF -> two frames, one-cycle ss-high gap, both words received.
REQ-038 Macro defined, miso driven with 0xA5A5A5A5 aligned to sck -> dout=0xA5A5A5A5 at done; macro undefined -> dout=0.
REQ-039 CLK_DIV=1, GAP=0 with din=0x80000001 -> sck period 2 cycles, ss low 65 cycles, word received correctly.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared constants and FSM state type for the byte-serial SPI transmitter.
package spi_pkg;

  localparam int SPI_WORD_BYTES = 4;
  localparam int SPI_BYTE_BITS  = 8;
  localparam int SPI_WORD_BITS  = SPI_WORD_BYTES * SPI_BYTE_BITS;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SHIFT_LO = 3'd1,
    SHIFT_HI = 3'd2,
    GAP      = 3'd3,
    HOLD     = 3'd4
  } spi_state_e;

endpackage

// File: rtl/spi_sck_gen.sv
// sck half-period timer: down-counter that ticks on the last cycle of each
// CLK_DIV-cycle phase and reloads whenever it is disabled.
module spi_sck_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= RELOAD;
    end else if (!en || tick) begin
      cnt <= RELOAD;
    end else begin
      cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/bytes_transmitter.sv
// Four-byte SPI mode-0 master. Optional miso capture into dout is enabled by
// defining BYTES_TRANSMITTER_MISO_CAPTURE_EN; otherwise dout is tied to zero.
//
// state    | meaning
// IDLE     | ss high, waiting for start
// SHIFT_LO | sck low half-period, mosi holds current bit
// SHIFT_HI | sck high half-period, miso sampled on entry
// GAP      | sck held low between bytes
// HOLD     | sck low trailing period before ss release
module bytes_transmitter
  import spi_pkg::*;
#(
  parameter int CLK_DIV        = 4,
  parameter int INTER_BYTE_GAP = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] din,
  input  logic        miso,
  output logic        ss,
  output logic        sck,
  output logic        mosi,
  output logic        busy,
  output logic        done,
  output logic [31:0] dout
);

  localparam int GW = (INTER_BYTE_GAP > 1) ? $clog2(INTER_BYTE_GAP) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'((INTER_BYTE_GAP > 0) ? INTER_BYTE_GAP - 1 : 0);
  localparam logic HAS_GAP = (INTER_BYTE_GAP > 0);

  spi_state_e state, state_nxt;
  logic [SPI_WORD_BITS-1:0] shreg;
  logic [2:0]               bit_cnt;
  logic [1:0]               byte_cnt;
  logic [GW-1:0]            gap_cnt;
  logic                     sck_en;
  logic                     tick;
  logic                     last_bit;

  assign sck_en   = (state == SHIFT_LO) || (state == SHIFT_HI) || (state == HOLD);
  assign last_bit = (bit_cnt == 3'd7);
  assign mosi     = shreg[SPI_WORD_BITS-1];

  spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (sck_en),
    .tick (tick)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start) state_nxt = SHIFT_LO;
      SHIFT_LO: if (tick)  state_nxt = SHIFT_HI;
      SHIFT_HI: begin
        if (tick) begin
          if (!last_bit)              state_nxt = SHIFT_LO;
          else if (byte_cnt == 2'd3)  state_nxt = HOLD;
          else if (HAS_GAP)           state_nxt = GAP;
          else                        state_nxt = SHIFT_LO;
        end
      end
      GAP:      if (gap_cnt == '0) state_nxt = SHIFT_LO;
      HOLD:     if (tick) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Pin outputs are registered from the next state so sck and ss are glitch-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      gap_cnt  <= '0;
      ss       <= 1'b1;
      sck      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state <= state_nxt;
      ss    <= (state_nxt == IDLE);
      sck   <= (state_nxt == SHIFT_HI);
      busy  <= (state_nxt != IDLE);
      done  <= (state == HOLD) && tick;
      case (state)
        IDLE: begin
          if (start) begin
            shreg    <= din;
            bit_cnt  <= '0;
            byte_cnt <= '0;
          end
        end
        SHIFT_HI: begin
          if (tick) begin
            shreg   <= {shreg[SPI_WORD_BITS-2:0], 1'b0};
            bit_cnt <= bit_cnt + 3'd1;
            gap_cnt <= GAP_LOAD;
            if (last_bit) byte_cnt <= byte_cnt + 2'd1;
          end
        end
        GAP: begin
          if (gap_cnt != '0) gap_cnt <= gap_cnt - GW'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef BYTES_TRANSMITTER_MISO_CAPTURE_EN
  logic [SPI_WORD_BITS-1:0] rx;

  // The SHIFT_LO tick edge is the same edge on which sck rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx   <= '0;
      dout <= '0;
    end else begin
      if ((state == SHIFT_LO) && tick) rx <= {rx[SPI_WORD_BITS-2:0], miso};
      if ((state == HOLD) && tick)     dout <= rx;
    end
  end
`else
  logic unused_miso;
  assign unused_miso = miso;
  assign dout        = '0;
`endif

endmodule

// File: tb/tb_bytes_transmitter.sv
// Self-checking bench: two instances (CLK_DIV=4/GAP=2 and CLK_DIV=1/GAP=0)
// checked against a word-level peripheral model.
module tb_bytes_transmitter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start0, start1;
  logic [31:0] din;
  logic        miso;
  logic        ss0, sck0, mosi0, busy0, done0;
  logic        ss1, sck1, mosi1, busy1, done1;
  logic [31:0] dout0, dout1;

  bytes_transmitter #(.CLK_DIV(4), .INTER_BYTE_GAP(2)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .din(din), .miso(miso),
    .ss(ss0), .sck(sck0), .mosi(mosi0), .busy(busy0), .done(done0), .dout(dout0)
  );

  bytes_transmitter #(.CLK_DIV(1), .INTER_BYTE_GAP(0)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .din(din), .miso(miso),
    .ss(ss1), .sck(sck1), .mosi(mosi1), .busy(busy1), .done(done1), .dout(dout1)
  );

  int          sel;
  logic        ss_m, sck_m, mosi_m, busy_m, done_m;
  logic [31:0] dout_m;
  assign ss_m   = (sel != 0) ? ss1   : ss0;
  assign sck_m  = (sel != 0) ? sck1  : sck0;
  assign mosi_m = (sel != 0) ? mosi1 : mosi0;
  assign busy_m = (sel != 0) ? busy1 : busy0;
  assign done_m = (sel != 0) ? done1 : done0;
  assign dout_m = (sel != 0) ? dout1 : dout0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_dout(input logic [31:0] miso_word);
`ifdef BYTES_TRANSMITTER_MISO_CAPTURE_EN
    return miso_word;
`else
    return 32'h0;
`endif
  endfunction

  task automatic set_start(input int s, input logic v);
    if (s != 0) start1 = v;
    else        start0 = v;
  endtask

  // Runs one frame as seen by a mode-0 peripheral and checks it against the word-level model.
  task automatic run_frame(input int s, input logic [31:0] word, input logic [31:0] miso_word,
                           input bit keep_start, input int poke_at, output int idle_before);
    int d, g, low, dones, bits, busy_bad, per_bad, last_rise, cyc, exp_int;
    bit started, finished;
    logic prev_sck, done_end;
    logic [31:0] rx, dout_end;
    d = (s != 0) ? 1 : 4;
    g = (s != 0) ? 0 : 2;
    low = 0; dones = 0; bits = 0; busy_bad = 0; per_bad = 0; last_rise = -1; cyc = 0;
    started = 0; finished = 0; prev_sck = 1'b0; rx = '0; done_end = 1'b0; dout_end = '0;
    idle_before = 0;
    sel = s;
    din = word;
    set_start(s, 1'b1);
    while (!finished && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (busy_m !== !ss_m) busy_bad++;
      if (done_m === 1'b1) dones++;
      if (poke_at > 0 && cyc == poke_at)     set_start(s, 1'b1);
      if (poke_at > 0 && cyc == poke_at + 1) set_start(s, 1'b0);
      if (ss_m === 1'b0) begin
        if (!started) begin
          started = 1;
          if (!keep_start) set_start(s, 1'b0);
          din = $urandom();
        end
        low++;
        if (sck_m === 1'b1 && prev_sck === 1'b0) begin
          rx = {rx[30:0], mosi_m};
          bits++;
          if (last_rise >= 0) begin
            exp_int = (((bits - 1) % 8) == 0) ? 2 * d + g : 2 * d;
            if (cyc - last_rise != exp_int) per_bad++;
          end
          last_rise = cyc;
        end
        if (sck_m === 1'b0 && bits < 32) miso = miso_word[31 - bits];
      end else if (started) begin
        finished = 1;
        done_end = done_m;
        dout_end = dout_m;
      end else begin
        idle_before++;
      end
      prev_sck = sck_m;
    end
    if (!finished) begin
      check("frame_timeout", 32'd1, 32'd0);
    end else begin
      check("rx_word", rx, word);
      check("rx_bits", bits, 32);
      check("ss_low_cycles", low, 64 * d + 3 * g + d);
      check("done_count", dones, 1);
      check("done_at_ss_rise", done_end, 1);
      check("dout_at_done", dout_end, exp_dout(miso_word));
      check("busy_vs_ss", busy_bad, 0);
      check("sck_intervals", per_bad, 0);
    end
  endtask

  task automatic idle_check(input int n);
    int lows, dns;
    lows = 0; dns = 0;
    repeat (n) begin
      @(negedge clk);
      if (ss_m !== 1'b1) lows++;
      if (done_m !== 1'b0) dns++;
    end
    check("idle_ss_low", lows, 0);
    check("idle_done", dns, 0);
  endtask

  initial begin
    int ib;
    logic [31:0] w, mw;
    sel = 0; rst = 1'b1; start0 = 1'b0; start1 = 1'b0; din = '0; miso = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ss0", ss0, 1);     check("rst_sck0", sck0, 0);
    check("rst_mosi0", mosi0, 0); check("rst_busy0", busy0, 0);
    check("rst_done0", done0, 0); check("rst_dout0", dout0, 0);
    check("rst_ss1", ss1, 1);     check("rst_dout1", dout1, 0);
    rst = 1'b0;
    @(negedge clk);

    run_frame(0, 32'hDEADBEEF, 32'hA5A5A5A5, 0, -1, ib);
    idle_check(10);

    run_frame(0, $urandom(), $urandom(), 0, 50, ib);
    idle_check(20);

    sel = 0; din = 32'h13579BDF; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (99) @(negedge clk);
    check("mid_frame_ss", ss0, 0);
    #1 rst = 1'b1;
    #1;
    check("abort_ss", ss0, 1);     check("abort_sck", sck0, 0);
    check("abort_mosi", mosi0, 0); check("abort_busy", busy0, 0);
    check("abort_done", done0, 0); check("abort_dout", dout0, 0);
    @(negedge clk);
    rst = 1'b0;
    idle_check(10);
    run_frame(0, 32'h01234567, 32'h5A5A0FF0, 0, -1, ib);
    idle_check(5);

    run_frame(0, 32'h00000000, 32'hFFFF0000, 1, -1, ib);
    din = 32'hFFFFFFFF;
    run_frame(0, 32'hFFFFFFFF, 32'h0000FFFF, 0, -1, ib);
    check("held_start_gap", ib, 0);
    idle_check(10);

    run_frame(1, 32'h80000001, 32'hA5A5A5A5, 0, -1, ib);
    idle_check(5);

    for (int i = 0; i < 6; i++) begin
      w  = $urandom();
      mw = $urandom();
      run_frame(i % 2, w, mw, 0, -1, ib);
      repeat ($urandom_range(1, 4)) @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
